// File: rtl/pad_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pad_input_conditioner
// Description : Conditions the raw pad inputs before the GPIO, JTAG and SPI
//               logic sees them. Each GPIO bit goes through a 2-flop
//               synchroniser, an optional glitch filter and a rise/fall
//               event detector. The strap pads are captured once, a fixed
//               number of edges after reset is released.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_input_conditioner #(
    parameter int NUM_GPIO      = 16,
    parameter int FILTER_CYCLES = 4,
    parameter int STRAP_DELAY   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_GPIO-1:0] gpio_pad_i,
    input  logic [NUM_GPIO-1:0] filter_en_i,
    input  logic [1:0]          strap_pad_i,
    output logic [NUM_GPIO-1:0] gpio_o,
    output logic [NUM_GPIO-1:0] gpio_rise_o,
    output logic [NUM_GPIO-1:0] gpio_fall_o,
    output logic                jtag_spi_n_o,
    output logic                boot_strap_o,
    output logic                strap_valid_o
);

    localparam int FCW = $clog2(FILTER_CYCLES) + 1;
    localparam int SCW = $clog2(STRAP_DELAY) + 1;
    localparam logic [FCW-1:0] FILT_LAST  = FCW'(FILTER_CYCLES - 1);
    localparam logic [SCW-1:0] STRAP_LAST = SCW'(STRAP_DELAY - 1);

    typedef enum logic [0:0] {
        ST_WAIT   = 1'b0,
        ST_LOCKED = 1'b1
    } strap_state_e;

    logic [NUM_GPIO-1:0] gpio_s1_q, gpio_s2_q;
    logic [1:0]          strap_s1_q, strap_s2_q;
    logic [NUM_GPIO-1:0] gpio_q, gpio_d;
    logic [NUM_GPIO-1:0] rise_q, fall_q;

    strap_state_e        state_q, state_d;
    logic [SCW-1:0]      scnt_q, scnt_d;
    logic                jtag_q, jtag_d;
    logic                boot_q, boot_d;
    logic                valid_q, valid_d;

    // Two-flop synchronisers for every asynchronous pad input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gpio_s1_q  <= '0;
            gpio_s2_q  <= '0;
            strap_s1_q <= '0;
            strap_s2_q <= '0;
        end else begin
            gpio_s1_q  <= gpio_pad_i;
            gpio_s2_q  <= gpio_s1_q;
            strap_s1_q <= strap_pad_i;
            strap_s2_q <= strap_s1_q;
        end
    end

    // Per-bit glitch filter: a change is accepted only after the synchronised
    // value has disagreed with the output for FILTER_CYCLES consecutive edges
    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_bit
        logic [FCW-1:0] cnt_q, cnt_d;
        logic           bit_d;

        // Next-state for this bit's output level and disagreement counter
        always_comb begin
            bit_d = gpio_q[i];
            cnt_d = '0;
            if (!filter_en_i[i]) begin
                bit_d = gpio_s2_q[i];
            end else if (gpio_s2_q[i] != gpio_q[i]) begin
                if (cnt_q == FILT_LAST) begin
                    bit_d = gpio_s2_q[i];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Disagreement counter register
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign gpio_d[i] = bit_d;
    end

    // Conditioned level plus edge pulses, aligned with the first cycle the new level is visible
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gpio_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            gpio_q <= gpio_d;
            rise_q <= gpio_d & ~gpio_q;
            fall_q <= ~gpio_d & gpio_q;
        end
    end

    // Strap FSM next-state: count edges after reset, capture once, then hold
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        jtag_d  = jtag_q;
        boot_d  = boot_q;
        valid_d = valid_q;
        case (state_q)
            ST_WAIT: begin
                if (scnt_q == STRAP_LAST) begin
                    jtag_d  = strap_s2_q[0];
                    boot_d  = strap_s2_q[1];
                    valid_d = 1'b1;
                    state_d = ST_LOCKED;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end
            default: begin
                state_d = ST_WAIT;
                scnt_d  = '0;
            end
        endcase
    end

    // Strap FSM registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_WAIT;
            scnt_q  <= '0;
            jtag_q  <= 1'b0;
            boot_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            jtag_q  <= jtag_d;
            boot_q  <= boot_d;
            valid_q <= valid_d;
        end
    end

    assign gpio_o        = gpio_q;
    assign gpio_rise_o   = rise_q;
    assign gpio_fall_o   = fall_q;
    assign jtag_spi_n_o  = jtag_q;
    assign boot_strap_o  = boot_q;
    assign strap_valid_o = valid_q;

endmodule
`default_nettype wire
